// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake.
// Payload bits are held across bubbles and flushes; control bits read as zero
// whenever the head slot is empty. SKID = 1 adds a second entry so that
// in_ready comes straight from a flop instead of from out_ready.
// A saturating counter tracks cycles in which downstream stalls a valid entry.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 8,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occ,
    input  logic               clr_stat,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [DATA_W-1:0]   main_data_r;
    logic [DATA_W-1:0]   main_data_nx_s;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [CTRL_W-1:0]   main_ctrl_nx_s;
    logic [DATA_W-1:0]   skid_data_r;
    logic [DATA_W-1:0]   skid_data_nx_s;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [CTRL_W-1:0]   skid_ctrl_nx_s;
    logic                out_valid_r;
    logic                out_valid_nx_s;
    logic [1:0]          occ_r;
    logic [1:0]          occ_nx_s;
    logic                in_ready_r;
    logic                alive_r;
    logic [STALL_W-1:0]  stall_cnt_r;
    logic [STALL_W-1:0]  stall_cnt_nx_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                pop_s;

    // Upstream ready: flopped in skid mode, pass-through of out_ready otherwise;
    // held low during reset and until the first live edge after it.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else if (SKID != 0) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = alive_r & (~out_valid_r | out_ready);
        end
    end

    assign accept_s = in_valid & in_ready_s;
    assign pop_s    = out_valid_r & out_ready;

    // Next-state and next-slot contents; flush wins over accept and pop.
    always_comb begin
        state_nx_s     = state_r;
        main_data_nx_s = main_data_r;
        main_ctrl_nx_s = main_ctrl_r;
        skid_data_nx_s = skid_data_r;
        skid_ctrl_nx_s = skid_ctrl_r;
        if (flush) begin
            state_nx_s     = ST_EMPTY;
            main_ctrl_nx_s = {CTRL_W{1'b0}};
            skid_ctrl_nx_s = {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nx_s     = ST_ONE;
                        main_data_nx_s = in_data;
                        main_ctrl_nx_s = in_ctrl;
                    end else begin
                        state_nx_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && (pop_s || (SKID == 0))) begin
                        state_nx_s     = ST_ONE;
                        main_data_nx_s = in_data;
                        main_ctrl_nx_s = in_ctrl;
                    end else if (accept_s) begin
                        state_nx_s     = ST_TWO;
                        skid_data_nx_s = in_data;
                        skid_ctrl_nx_s = in_ctrl;
                    end else if (pop_s) begin
                        state_nx_s     = ST_EMPTY;
                        main_ctrl_nx_s = {CTRL_W{1'b0}};
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_nx_s     = ST_ONE;
                        main_data_nx_s = skid_data_r;
                        main_ctrl_nx_s = skid_ctrl_r;
                        skid_ctrl_nx_s = {CTRL_W{1'b0}};
                    end else begin
                        state_nx_s = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s     = ST_EMPTY;
                    main_ctrl_nx_s = {CTRL_W{1'b0}};
                    skid_ctrl_nx_s = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // Decode occupancy and head validity from the next state so both are flopped.
    always_comb begin
        occ_nx_s       = 2'd0;
        out_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_EMPTY: begin
                occ_nx_s       = 2'd0;
                out_valid_nx_s = 1'b0;
            end
            ST_ONE: begin
                occ_nx_s       = 2'd1;
                out_valid_nx_s = 1'b1;
            end
            ST_TWO: begin
                occ_nx_s       = 2'd2;
                out_valid_nx_s = 1'b1;
            end
            default: begin
                occ_nx_s       = 2'd0;
                out_valid_nx_s = 1'b0;
            end
        endcase
    end

    // Stall counter: clear beats increment, saturates, frozen during flush.
    always_comb begin
        stall_cnt_nx_s = stall_cnt_r;
        if (clr_stat) begin
            stall_cnt_nx_s = {STALL_W{1'b0}};
        end else if (out_valid_r && !out_ready && !flush && !(&stall_cnt_r)) begin
            stall_cnt_nx_s = stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_nx_s = stall_cnt_r;
        end
    end

    // State, slot and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
            in_ready_r  <= 1'b0;
            alive_r     <= 1'b0;
            stall_cnt_r <= {STALL_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            main_data_r <= main_data_nx_s;
            main_ctrl_r <= main_ctrl_nx_s;
            skid_data_r <= skid_data_nx_s;
            skid_ctrl_r <= skid_ctrl_nx_s;
            out_valid_r <= out_valid_nx_s;
            occ_r       <= occ_nx_s;
            in_ready_r  <= (state_nx_s != ST_TWO);
            alive_r     <= 1'b1;
            stall_cnt_r <= stall_cnt_nx_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign out_ctrl  = main_ctrl_r;
    assign occ       = occ_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances on shared inputs
// (a: SKID=1, b: SKID=0, c: SKID=1 with 4-bit stall counter).
module tb_pipe_stage_reg;

    localparam int ND = 3;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;
    logic         out_ready;
    logic         clr_stat;

    logic         ir_a, ir_b, ir_c;
    logic         ov_a, ov_b, ov_c;
    logic [127:0] od_a, od_b, od_c;
    logic [7:0]   oc_a, oc_b, oc_c;
    logic [1:0]   occ_a, occ_b, occ_c;
    logic [15:0]  st_a, st_b;
    logic [3:0]   st_c;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1), .STALL_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_ctrl(oc_a), .occ(occ_a), .clr_stat(clr_stat), .stall_cnt(st_a));

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(0), .STALL_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_ctrl(oc_b), .occ(occ_b), .clr_stat(clr_stat), .stall_cnt(st_b));

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1), .STALL_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_ctrl(oc_c), .occ(occ_c), .clr_stat(clr_stat), .stall_cnt(st_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference: each instance is a FIFO of entries with a capacity and a held head value.
    logic [127:0] m_dat   [ND][2];
    logic [7:0]   m_ctl   [ND][2];
    int           m_cnt   [ND];
    logic [127:0] m_last  [ND];
    bit           m_alive [ND];
    int           m_stall [ND];
    bit           p_ready [ND];
    bit           m_skid  [ND];
    int           m_smax  [ND];

    task automatic chk(input string nm, input int id, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, id, act, exp, $time);
    endtask

    // Settle combinational outputs, predict this cycle's outputs, compare.
    task automatic eval_cycle();
        logic         a_ir, a_ov;
        logic [127:0] a_od;
        logic [7:0]   a_oc;
        logic [1:0]   a_occ;
        logic [15:0]  a_st;
        #1;
        for (int i = 0; i < ND; i++) begin
            p_ready[i] = rst_n && m_alive[i] &&
                         (m_skid[i] ? (m_cnt[i] < 2) : ((m_cnt[i] == 0) || out_ready));
            case (i)
                0: begin a_ir = ir_a; a_ov = ov_a; a_od = od_a; a_oc = oc_a; a_occ = occ_a; a_st = st_a; end
                1: begin a_ir = ir_b; a_ov = ov_b; a_od = od_b; a_oc = oc_b; a_occ = occ_b; a_st = st_b; end
                default: begin a_ir = ir_c; a_ov = ov_c; a_od = od_c; a_oc = oc_c; a_occ = occ_c; a_st = {12'd0, st_c}; end
            endcase
            if (chk_en) begin
                chk("in_ready", i, {127'd0, a_ir}, {127'd0, p_ready[i]});
                chk("out_valid", i, {127'd0, a_ov}, {127'd0, (m_cnt[i] > 0)});
                chk("out_data", i, a_od, (m_cnt[i] > 0) ? m_dat[i][0] : m_last[i]);
                chk("out_ctrl", i, {120'd0, a_oc}, {120'd0, ((m_cnt[i] > 0) ? m_ctl[i][0] : 8'h00)});
                chk("occ", i, {126'd0, a_occ}, 128'(m_cnt[i]));
                chk("stall_cnt", i, {112'd0, a_st}, 128'(m_stall[i]));
            end
        end
    endtask

    // Advance the reference at the rising edge, then return at the falling edge.
    task automatic edge_cycle();
        bit acc, pop;
        @(posedge clk);
        for (int i = 0; i < ND; i++) begin
            if (!rst_n) begin
                m_cnt[i] = 0; m_alive[i] = 1'b0; m_stall[i] = 0; m_last[i] = 128'd0;
            end else begin
                acc = in_valid && p_ready[i];
                pop = (m_cnt[i] > 0) && out_ready;
                if (clr_stat) m_stall[i] = 0;
                else if ((m_cnt[i] > 0) && !out_ready && !flush && (m_stall[i] < m_smax[i])) m_stall[i]++;
                if (flush) begin
                    m_cnt[i] = 0;
                end else begin
                    if (pop) begin
                        m_dat[i][0] = m_dat[i][1]; m_ctl[i][0] = m_ctl[i][1]; m_cnt[i]--;
                    end
                    if (acc) begin
                        m_dat[i][m_cnt[i]] = in_data; m_ctl[i][m_cnt[i]] = in_ctrl; m_cnt[i]++;
                    end
                end
                m_alive[i] = 1'b1;
                if (m_cnt[i] > 0) m_last[i] = m_dat[i][0];
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] pc;
        logic [7:0]  ct;
        logic        ordy, clr;
        logic        e_ir, e_ov;
        logic [31:0] e_pc;
        logic [7:0]  e_ct;
        logic [1:0]  e_occ;
        logic [15:0] e_st;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, iv, input logic [31:0] pc, input logic [7:0] ct,
                                input logic ordy, clr, e_ir, e_ov, input logic [31:0] e_pc,
                                input logic [7:0] e_ct, input logic [1:0] e_occ, input logic [15:0] e_st);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ct = ct; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ct = e_ct; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [31];
        //            rst fl iv pc            ct     ordy clr | ir ov pc            ct     occ st
        tv[0]  = mk(0, 0, 0, 32'h0,        8'h00, 0, 0,  0, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[1]  = mk(1, 0, 1, 32'h80000000, 8'h11, 1, 0,  0, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[2]  = mk(1, 0, 1, 32'h80000000, 8'h11, 1, 0,  1, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[3]  = mk(1, 0, 1, 32'h80000004, 8'h12, 1, 0,  1, 1, 32'h80000000, 8'h11, 2'd1, 16'd0);
        tv[4]  = mk(1, 0, 1, 32'h80000008, 8'h13, 1, 0,  1, 1, 32'h80000004, 8'h12, 2'd1, 16'd0);
        tv[5]  = mk(1, 0, 0, 32'h0,        8'h00, 0, 0,  1, 1, 32'h80000008, 8'h13, 2'd1, 16'd0);
        tv[6]  = mk(1, 0, 0, 32'h0,        8'h00, 1, 0,  1, 1, 32'h80000008, 8'h13, 2'd1, 16'd1);
        tv[7]  = mk(1, 0, 1, 32'h100,      8'h21, 0, 0,  1, 0, 32'h80000008, 8'h00, 2'd0, 16'd1);
        tv[8]  = mk(1, 0, 1, 32'h200,      8'h22, 0, 0,  1, 1, 32'h100,      8'h21, 2'd1, 16'd1);
        tv[9]  = mk(1, 0, 1, 32'h300,      8'h23, 0, 0,  0, 1, 32'h100,      8'h21, 2'd2, 16'd2);
        tv[10] = mk(1, 0, 1, 32'h300,      8'h23, 0, 0,  0, 1, 32'h100,      8'h21, 2'd2, 16'd3);
        tv[11] = mk(1, 0, 1, 32'h300,      8'h23, 1, 0,  0, 1, 32'h100,      8'h21, 2'd2, 16'd4);
        tv[12] = mk(1, 0, 1, 32'h300,      8'h23, 1, 0,  1, 1, 32'h200,      8'h22, 2'd1, 16'd4);
        tv[13] = mk(1, 0, 0, 32'h0,        8'h00, 1, 0,  1, 1, 32'h300,      8'h23, 2'd1, 16'd4);
        tv[14] = mk(1, 0, 0, 32'h0,        8'h00, 1, 0,  1, 0, 32'h300,      8'h00, 2'd0, 16'd4);
        tv[15] = mk(1, 0, 1, 32'h400,      8'h31, 0, 0,  1, 0, 32'h300,      8'h00, 2'd0, 16'd4);
        tv[16] = mk(1, 0, 1, 32'h500,      8'h32, 0, 0,  1, 1, 32'h400,      8'h31, 2'd1, 16'd4);
        tv[17] = mk(1, 1, 1, 32'h600,      8'h33, 0, 0,  0, 1, 32'h400,      8'h31, 2'd2, 16'd5);
        tv[18] = mk(1, 0, 0, 32'h0,        8'h00, 0, 0,  1, 0, 32'h400,      8'h00, 2'd0, 16'd5);
        tv[19] = mk(1, 0, 0, 32'h0,        8'h00, 1, 1,  1, 0, 32'h400,      8'h00, 2'd0, 16'd5);
        tv[20] = mk(1, 0, 1, 32'h700,      8'h41, 1, 0,  1, 0, 32'h400,      8'h00, 2'd0, 16'd0);
        tv[21] = mk(1, 1, 1, 32'h800,      8'h42, 1, 0,  1, 1, 32'h700,      8'h41, 2'd1, 16'd0);
        tv[22] = mk(1, 0, 0, 32'h0,        8'h00, 1, 0,  1, 0, 32'h700,      8'h00, 2'd0, 16'd0);
        tv[23] = mk(1, 0, 1, 32'h900,      8'h51, 0, 0,  1, 0, 32'h700,      8'h00, 2'd0, 16'd0);
        tv[24] = mk(1, 0, 1, 32'hA00,      8'h52, 0, 0,  1, 1, 32'h900,      8'h51, 2'd1, 16'd0);
        tv[25] = mk(1, 0, 0, 32'h0,        8'h00, 0, 0,  0, 1, 32'h900,      8'h51, 2'd2, 16'd1);
        tv[26] = mk(0, 0, 1, 32'h0,        8'h00, 0, 0,  0, 1, 32'h900,      8'h51, 2'd2, 16'd2);
        tv[27] = mk(0, 0, 1, 32'hB00,      8'h61, 1, 0,  0, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[28] = mk(1, 0, 1, 32'hB00,      8'h61, 1, 0,  0, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[29] = mk(1, 0, 1, 32'hB00,      8'h61, 1, 0,  1, 0, 32'h0,        8'h00, 2'd0, 16'd0);
        tv[30] = mk(1, 0, 0, 32'h0,        8'h00, 1, 0,  1, 1, 32'hB00,      8'h61, 2'd1, 16'd0);

        m_skid[0] = 1'b1; m_smax[0] = 65535;
        m_skid[1] = 1'b0; m_smax[1] = 65535;
        m_skid[2] = 1'b1; m_smax[2] = 15;
        for (int i = 0; i < ND; i++) begin
            m_cnt[i] = 0; m_alive[i] = 1'b0; m_stall[i] = 0; m_last[i] = 128'd0;
        end

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 128'd0;
        in_ctrl = 8'd0; out_ready = 1'b0; clr_stat = 1'b0;
        @(negedge clk);
        eval_cycle(); edge_cycle();
        eval_cycle(); edge_cycle();
        chk_en = 1'b1;

        // Directed table on instance a: streaming, backpressure, flush, clear, reset.
        for (int k = 0; k < 31; k++) begin
            rst_n = tv[k].rst; flush = tv[k].fl; in_valid = tv[k].iv;
            in_data = {96'd0, tv[k].pc}; in_ctrl = tv[k].ct;
            out_ready = tv[k].ordy; clr_stat = tv[k].clr;
            eval_cycle();
            chk($sformatf("tv%0d in_ready", k), 0, {127'd0, ir_a}, {127'd0, tv[k].e_ir});
            chk($sformatf("tv%0d out_valid", k), 0, {127'd0, ov_a}, {127'd0, tv[k].e_ov});
            chk($sformatf("tv%0d out_data", k), 0, od_a, {96'd0, tv[k].e_pc});
            chk($sformatf("tv%0d out_ctrl", k), 0, {120'd0, oc_a}, {120'd0, tv[k].e_ct});
            chk($sformatf("tv%0d occ", k), 0, {126'd0, occ_a}, {126'd0, tv[k].e_occ});
            chk($sformatf("tv%0d stall_cnt", k), 0, {112'd0, st_a}, {112'd0, tv[k].e_st});
            edge_cycle();
        end

        // SKID=0 bubble and same-cycle ready follow on instance b.
        rst_n = 1'b1; flush = 1'b0; clr_stat = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        eval_cycle(); edge_cycle();
        eval_cycle(); edge_cycle();
        in_valid = 1'b1; in_data = 128'h1234; in_ctrl = 8'hFF;
        eval_cycle(); edge_cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        eval_cycle();
        chk("bubble ov_full", 1, {127'd0, ov_b}, 128'd1);
        chk("bubble ctrl_full", 1, {120'd0, oc_b}, 128'hFF);
        chk("s0 ready_low", 1, {127'd0, ir_b}, 128'd0);
        out_ready = 1'b1;
        eval_cycle();
        chk("s0 ready_follow", 1, {127'd0, ir_b}, 128'd1);
        edge_cycle();
        eval_cycle();
        chk("bubble ov_empty", 1, {127'd0, ov_b}, 128'd0);
        chk("bubble ctrl_zero", 1, {120'd0, oc_b}, 128'h00);
        edge_cycle();

        // Stall saturation on the 4-bit counter of instance c.
        clr_stat = 1'b1; in_valid = 1'b1; in_data = 128'h5555; in_ctrl = 8'h5A; out_ready = 1'b1;
        eval_cycle(); edge_cycle();
        clr_stat = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            eval_cycle(); edge_cycle();
        end
        eval_cycle();
        chk("sat stall_c", 2, {124'd0, st_c}, 128'hF);
        chk("sat stall_a", 0, {112'd0, st_a}, 128'd20);
        clr_stat = 1'b1;
        edge_cycle();
        clr_stat = 1'b0;
        eval_cycle();
        chk("clr stall_c", 2, {124'd0, st_c}, 128'd0);
        edge_cycle();

        // Randomised traffic against the reference.
        for (int k = 0; k < 800; k++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            clr_stat  = ($urandom_range(0, 31) == 0);
            eval_cycle();
            edge_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
